exmem_latch: RTL
================

// Module: exmem_latch
// PURPOSE
//  EX/MEM pipeline register plus data-memory access controller. Captures the execute-stage result
//  and issues any load/store to dcache. Holds the pipeline (exm_busy) until dhit.
//  Its exm_WEN/exm_wsel_out/exm_outport outputs feed the forward unit and the MEM/WB latch.
// PARAMETERS
//  WORD_W    32   data/address width
//  REG_W     5    register-select width
//  MAX_WAIT  255  cycles in MEM_WAIT before exm_timeout asserts
// PORTS
//  CLK           in   1       clock, all state on rising edge
//  RST           in   1       synchronous, active-high reset
//  en            in   1       pipeline advance (ihit && !hazard stall)
//  flush         in   1       insert bubble on capture (branch/jump taken)
//  idex_alu_out  in   WORD_W  ALU result / effective address
//  idex_store    in   WORD_W  forwarded rt data (post-ForwardB mux)
//  idex_wsel     in   REG_W   destination register
//  idex_WEN      in   1       register write enable
//  idex_dREN     in   1       load
//  idex_dWEN     in   1       store
//  idex_atomic   in   1       LL (with dREN) / SC (with dWEN)
//  idex_halt     in   1       halt marker
//  dhit          in   1       dcache completes current request
//  dload         in   WORD_W  dcache read data
//  snoop_valid   in   1       external write/invalidate observed
//  snoop_addr    in   WORD_W  address of that write
//  exm_WEN       out  1       latched register write enable
//  exm_wsel_out  out  REG_W   latched destination
//  exm_outport   out  WORD_W  ALU result, or SC status after SC completes
//  exm_dload     out  WORD_W  load data captured on dhit
//  exm_halt      out  1       latched halt
//  dmemREN       out  1       dcache read request
//  dmemWEN       out  1       dcache write request
//  dmemaddr      out  WORD_W  = latched alu_out
//  dmemstore     out  WORD_W  = latched store data
//  exm_busy      out  1       stall upstream stages
//  exm_timeout   out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset: all outputs and registers 0; FSM -> IDLE; counter 0; link invalid.
//  - FSM states: IDLE, MEM_WAIT.
//    - Capture occurs when en && !exm_busy.
//    - On capture with flush=1: bubble is latched (WEN, dREN, dWEN, halt, atomic = 0; data fields don't-care).
//    - On capture with a memory op (dREN|dWEN, after SC gating): IDLE -> MEM_WAIT.
//  - MEM_WAIT:
//    - dmemREN/dmemWEN are driven from the latched op; both are 0 in IDLE.
//    - On dhit: exm_dload <= dload; return to IDLE.
//    - exm_busy = (state==MEM_WAIT) && !dhit. Combinational, so there is zero-cycle release on the dhit cycle.
//  - flush or en while in MEM_WAIT: ignored. The in-flight op is older than the flushing branch, so it always completes.
//  - Simultaneous dhit and en: the op completes and the next instruction is captured in the same edge.
//  - Watchdog:
//    - Counter increments each MEM_WAIT cycle without dhit; it clears on IDLE entry.
//    - At MAX_WAIT the counter saturates and exm_timeout sets; only RST clears exm_timeout.
//  - RST mid-request: drops dmemREN/dmemWEN the next cycle; the pending op is discarded.
//  - exm_WEN is qualified only by the latch. The forward unit ignores wsel 0, so no masking here.
// CONFIGURATION
//  EXMEM_LLSC_EN defined: LL/SC support.
//    - Link register {valid, addr} lives inside the block.
//    - LL, on dhit: valid <= 1, addr <= dmemaddr.
//    - SC capture:
//      - success if valid && addr==alu_out: store issued, exm_outport=1, valid <= 0.
//      - failure otherwise: dWEN suppressed, no request, stays IDLE, exm_outport=0.
//    - Link clear: snoop_valid && snoop_addr==addr clears valid. This takes priority over an LL on the same cycle.
//  EXMEM_LLSC_EN undefined:
//    - idex_atomic, snoop_valid and snoop_addr are ignored.
//    - SC behaves as a plain SW; exm_outport = alu_out.
// STRUCTURE
//  - cpu_types_pkg provides:
//    - word_t and regbits_t
//    - enum exm_state_t {IDLE, MEM_WAIT}
//  - Optional sub-module exmem_link_reg (LL/SC link register + compare), instantiated only under EXMEM_LLSC_EN.
//  - Interface bundling follows exmem_latch_if, connected like forward_unit_if.
// TESTING
//  1. ALU op: en=1, alu_out=0x1234, wsel=8, WEN=1 -> next cycle exm_outport=0x1234, exm_wsel_out=8, exm_WEN=1, busy=0.
//  2. Load with dhit after 3 cycles, alu_out=0x40, dload=0xDEADBEEF:
//     - dmemREN=1 and dmemaddr=0x40 for 3 cycles
//     - exm_busy high 2 cycles, low on the dhit cycle
//     - exm_dload=0xDEADBEEF
//  3. flush=1 with en=1 on a store -> exm_WEN=0, dmemWEN never asserts; flush during MEM_WAIT -> store still completes.
//  4. MAX_WAIT=4, dhit held 0 -> exm_timeout=1 after 4 waiting cycles; RST -> timeout=0, dmemREN=0, state IDLE.
//  5. (EXMEM_LLSC_EN) LL 0x80, SC 0x80 -> dmemWEN=1, outport=1.
//     LL 0x80, snoop 0x80, SC 0x80 -> no dmemWEN, outport=0, busy=0.
//  6. dhit and new en in the same cycle -> back-to-back loads 0x10, 0x14 issue with no idle gap.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the EX/MEM controller state encoding.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_W  = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_W-1:0]  regbits_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } exm_state_t;

endpackage

// File: rtl/exmem_link_reg.sv
// LL/SC link register: remembers the address of the last completed LL and
// reports whether an SC address still matches a live link.
module exmem_link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ll_set,
    input  logic [WORD_W-1:0] i_ll_addr,
    input  logic              i_sc_commit,
    input  logic              i_snoop_valid,
    input  logic [WORD_W-1:0] i_snoop_addr,
    input  logic [WORD_W-1:0] i_cmp_addr,
    output logic              o_match
);

    logic              r_valid;
    logic [WORD_W-1:0] r_addr;

    // Link update; a snoop hitting the link address wins over a same-cycle LL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_ll_set) begin
            r_addr  <= i_ll_addr;
            r_valid <= !(i_snoop_valid && (i_snoop_addr == i_ll_addr));
        end else if ((i_snoop_valid && (i_snoop_addr == r_addr)) || i_sc_commit) begin
            r_valid <= 1'b0;
        end
    end

    assign o_match = r_valid && (r_addr == i_cmp_addr);

endmodule

// File: rtl/exmem_latch.sv
// EX/MEM pipeline register with data-cache access controller and watchdog.
// Optional LL/SC support is enabled by defining EXMEM_LLSC_EN.
module exmem_latch
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = CPU_WORD_W,
    parameter int REG_W    = CPU_REG_W,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic [WORD_W-1:0] idex_alu_out,
    input  logic [WORD_W-1:0] idex_store,
    input  logic [REG_W-1:0]  idex_wsel,
    input  logic              idex_WEN,
    input  logic              idex_dREN,
    input  logic              idex_dWEN,
    input  logic              idex_atomic,
    input  logic              idex_halt,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_valid,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              exm_WEN,
    output logic [REG_W-1:0]  exm_wsel_out,
    output logic [WORD_W-1:0] exm_outport,
    output logic [WORD_W-1:0] exm_dload,
    output logic              exm_halt,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              exm_busy,
    output logic              exm_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    exm_state_t        r_state;
    logic              r_wen;
    logic [REG_W-1:0]  r_wsel;
    logic [WORD_W-1:0] r_alu;
    logic [WORD_W-1:0] r_store;
    logic [WORD_W-1:0] r_outport;
    logic [WORD_W-1:0] r_dload;
    logic              r_dren;
    logic              r_dwen;
    logic              r_halt;
    logic              r_atomic;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;

    logic              w_busy;
    logic              w_capture;
    logic              w_done;
    logic              w_dwen_eff;
    logic              w_memop;
    logic [WORD_W-1:0] w_outport_next;

    assign w_done    = (r_state == MEM_WAIT) && dhit;
    assign w_busy    = (r_state == MEM_WAIT) && !dhit;
    assign w_capture = en && !w_busy;

`ifdef EXMEM_LLSC_EN
    logic w_is_sc;
    logic w_sc_ok;
    logic w_ll_set;
    logic w_sc_commit;

    assign w_is_sc        = idex_atomic && idex_dWEN;
    assign w_dwen_eff     = idex_dWEN && (!w_is_sc || w_sc_ok);
    assign w_outport_next = w_is_sc ? WORD_W'(w_sc_ok) : idex_alu_out;
    assign w_ll_set       = w_done && r_dren && r_atomic;
    assign w_sc_commit    = w_capture && !flush && w_is_sc && w_sc_ok;

    exmem_link_reg #(
        .WORD_W(WORD_W)
    ) u_link (
        .clk          (CLK),
        .rst          (RST),
        .i_ll_set     (w_ll_set),
        .i_ll_addr    (r_alu),
        .i_sc_commit  (w_sc_commit),
        .i_snoop_valid(snoop_valid),
        .i_snoop_addr (snoop_addr),
        .i_cmp_addr   (idex_alu_out),
        .o_match      (w_sc_ok)
    );
`else
    logic w_unused;

    assign w_dwen_eff     = idex_dWEN;
    assign w_outport_next = idex_alu_out;
    assign w_unused       = ^{idex_atomic, snoop_valid, snoop_addr, r_atomic};
`endif

    assign w_memop = idex_dREN || w_dwen_eff;

    // Pipeline latch and request FSM; a completing op and a new capture may share an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_wen     <= 1'b0;
            r_wsel    <= '0;
            r_alu     <= '0;
            r_store   <= '0;
            r_outport <= '0;
            r_dload   <= '0;
            r_dren    <= 1'b0;
            r_dwen    <= 1'b0;
            r_halt    <= 1'b0;
            r_atomic  <= 1'b0;
        end else begin
            if (w_capture) begin
                if (flush) begin
                    r_wen    <= 1'b0;
                    r_dren   <= 1'b0;
                    r_dwen   <= 1'b0;
                    r_halt   <= 1'b0;
                    r_atomic <= 1'b0;
                    r_state  <= IDLE;
                end else begin
                    r_wen     <= idex_WEN;
                    r_wsel    <= idex_wsel;
                    r_alu     <= idex_alu_out;
                    r_store   <= idex_store;
                    r_outport <= w_outport_next;
                    r_dren    <= idex_dREN;
                    r_dwen    <= w_dwen_eff;
                    r_halt    <= idex_halt;
                    r_atomic  <= idex_atomic;
                    r_state   <= w_memop ? MEM_WAIT : IDLE;
                end
            end else if (w_done) begin
                r_state <= IDLE;
            end
            if (w_done) begin
                r_dload <= dload;
            end
        end
    end

    // Watchdog: count un-hit wait cycles, saturate at MAX_WAIT, sticky flag until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_busy) begin
            if (r_cnt != CNT_W'(MAX_WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt >= CNT_W'(MAX_WAIT - 1)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign exm_WEN      = r_wen;
    assign exm_wsel_out = r_wsel;
    assign exm_outport  = r_outport;
    assign exm_dload    = r_dload;
    assign exm_halt     = r_halt;
    assign dmemREN      = (r_state == MEM_WAIT) && r_dren;
    assign dmemWEN      = (r_state == MEM_WAIT) && r_dwen;
    assign dmemaddr     = r_alu;
    assign dmemstore    = r_store;
    assign exm_busy     = w_busy;
    assign exm_timeout  = r_timeout;

endmodule
